// File: rtl/mem_sched_pkg.sv
// Shared definitions for the memory scheduler slice.
//   - Scheduler state encoding (IDLE=0, BUSY=1, FAULT=2).
//   - Memory bus field widths and the stall-counter width.
package core_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int TMO_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FAULT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/mem_sched_if.sv
// Requester-side and memory-side signals of the memory scheduler.
//   master : the scheduler's view (consumes requests, drives the memory port)
//   slave  : the environment's view (requesters plus memory)
// Packed per-requester fields: requester i occupies [W*i +: W].
interface mem_sched_if
    import core_pkg::*;
#(
    parameter int NREQ = 2
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [ADDR_W*NREQ-1:0] req_addr;
    logic [DATA_W*NREQ-1:0] req_wdata;
    logic [STRB_W*NREQ-1:0] req_wstrb;
    logic [DATA_W-1:0]      req_rdata;

    logic                   mem_valid;
    logic                   mem_ready;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [STRB_W-1:0]      mem_wstrb;
    logic [DATA_W-1:0]      mem_rdata;

    logic                   fault;

    modport master (
        input  req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
        output req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb, fault
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
        input  req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb, fault
    );

endinterface

// File: rtl/mem_sched_rr_pick.sv
// rr_pick: combinational circular priority picker.
//   req : request vector
//   ptr : index with highest priority
//   any : at least one request set
//   idx : first set index scanning upward from ptr, wrapping NREQ-1 -> 0
// The wrap is an explicit subtraction so non-power-of-2 NREQ works.
module rr_pick #(
    parameter  int NREQ = 2,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx
);

    always_comb begin
        int cand;
        any  = 1'b0;
        idx  = ptr;
        cand = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any && req[PW'(cand)]) begin
                any = 1'b1;
                idx = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_sched.sv
// mem_sched: round-robin scheduler sharing one memory port among NREQ
// requesters. A transaction is granted whole and held until mem_ready; the
// next arbitration starts from the requester after the last completed grant.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - mem_sched_if.master (requester handshakes, memory port, fault)
// Parameters:
//   NREQ    - number of requesters, 2..8
//   TIMEOUT - stalled BUSY cycles tolerated before fault (timeout build only)
// Build option:
//   MEM_SCHED_TIMEOUT_EN - enables the stall counter and the sticky FAULT
//   state; without it BUSY waits indefinitely and fault is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; arbitrate among req_valid from ptr
// BUSY  | granted access presented on the memory port until mem_ready
// FAULT | memory stalled past TIMEOUT; port quiet until reset
module mem_sched
    import core_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    mem_sched_if.master bus
);

    localparam int PW = $clog2(NREQ);

    sched_state_t  state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] grant_q, grant_d;
    logic          pick_any;
    logic [PW-1:0] pick_idx;
    logic          busy;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign busy = (state_q == ST_BUSY);

`ifdef MEM_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT));

    // Held at zero through IDLE, which is the same as clearing on BUSY entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else if (state_q == ST_IDLE) begin
            tmo_q <= '0;
        end else if (busy && !bus.mem_ready) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign bus.fault = (state_q == ST_FAULT);
`else
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    ptr_d   = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
                    state_d = ST_IDLE;
                end
`ifdef MEM_SCHED_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = ST_FAULT;
                end
`endif
            end
`ifdef MEM_SCHED_TIMEOUT_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion pulse goes only to the granted requester, straight from mem_ready.
    always_comb begin
        bus.req_ready = '0;
        if (busy) begin
            bus.req_ready[grant_q] = bus.mem_ready;
        end
    end

    assign bus.mem_valid = busy;
    assign bus.mem_addr  = bus.req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign bus.mem_wdata = bus.req_wdata[int'(grant_q)*DATA_W +: DATA_W];
    assign bus.mem_wstrb = busy ? bus.req_wstrb[int'(grant_q)*STRB_W +: STRB_W] : '0;
    assign bus.req_rdata = bus.mem_rdata;

endmodule
